counter_event_logger: RTL

Downstream consumer of the two sample counters. Samples `count1` and `count2` every `sys_clk`, detects value changes, and packs each change into a 32-bit event word. Event words are buffered in an internal FIFO that the host drains through a pipe-out style read port. Status (level, overflow drops) is exported for wire-out endpoints.

---
 rtl/counter_event_logger.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/counter_event_logger.sv
// Change-detecting event logger for two 8-bit counters, with a FIFO read out through a pipe-out style port.
// Define COUNTER_EVENT_TIMESTAMP_EN to stamp every event word with a 16-bit cycle count in bits [31:16].
module counter_event_logger #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_W     = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  arm,
    input  logic                  clear,
    input  logic [7:0]            count1,
    input  logic [7:0]            count2,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    // Sample stage: previous values, registered change flags and the capture timestamp
    logic [7:0]  prev1, prev2;
    logic        det1, det2;
    logic [7:0]  det1_val, det2_val;
    logic [15:0] det_ts;
    logic [15:0] ts_now;

    // One-entry holding slot for a count2 event that lost arbitration
    logic        pend_v;
    logic [7:0]  pend_val;
    logic [15:0] pend_ts;
    logic        pend_v_next;
    logic [7:0]  pend_val_next;
    logic [15:0] pend_ts_next;

    // FIFO storage and bookkeeping
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [5:0]            seq;
    logic [DEPTH_LOG2:0]   level_next;

    // Write-side arbitration results
    logic        wr_req;
    logic        wr_ok;
    logic        pop;
    logic [1:0]  wr_src;
    logic [7:0]  wr_val;
    logic [15:0] wr_ts;
    logic [31:0] wr_word;
    logic [1:0]  drop_inc;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_next;

`ifdef COUNTER_EVENT_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_cnt <= 16'h0000;
        end else begin
            ts_cnt <= ts_cnt + 16'h0001;
        end
    end

    assign ts_now = ts_cnt;
`else
    assign ts_now = 16'h0000;
`endif

    // prev registers track the inputs regardless of arm so that arming never sees stale values
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev1    <= 8'h00;
            prev2    <= 8'h00;
            det1     <= 1'b0;
            det2     <= 1'b0;
            det1_val <= 8'h00;
            det2_val <= 8'h00;
            det_ts   <= 16'h0000;
        end else begin
            prev1    <= count1;
            prev2    <= count2;
            det1     <= arm && !clear && (count1 != prev1);
            det2     <= arm && !clear && (count2 != prev2);
            det1_val <= count1;
            det2_val <= count2;
            det_ts   <= ts_now;
        end
    end

    // count1 wins the single write slot; an older pending count2 beats a fresh count2 event
    always_comb begin
        wr_req        = 1'b0;
        wr_src        = 2'b00;
        wr_val        = 8'h00;
        wr_ts         = 16'h0000;
        pend_v_next   = pend_v;
        pend_val_next = pend_val;
        pend_ts_next  = pend_ts;
        drop_inc      = 2'd0;

        if (det1) begin
            wr_req = 1'b1;
            wr_src = 2'b01;
            wr_val = det1_val;
            wr_ts  = det_ts;
            if (det2) begin
                if (pend_v) begin
                    drop_inc = 2'd1;
                end
                pend_v_next   = 1'b1;
                pend_val_next = det2_val;
                pend_ts_next  = det_ts;
            end
        end else if (pend_v) begin
            wr_req        = 1'b1;
            wr_src        = 2'b10;
            wr_val        = pend_val;
            wr_ts         = pend_ts;
            pend_v_next   = det2;
            pend_val_next = det2_val;
            pend_ts_next  = det_ts;
        end else if (det2) begin
            wr_req = 1'b1;
            wr_src = 2'b10;
            wr_val = det2_val;
            wr_ts  = det_ts;
        end

        pop   = rd_en && !empty;
        wr_ok = wr_req && (!full || pop);
        if (wr_req && !wr_ok) begin
            drop_inc = drop_inc + 2'd1;
        end
    end

    assign wr_word = {wr_ts, wr_src, seq, wr_val};

    always_comb begin
        level_next = level;
        if (wr_ok && !pop) begin
            level_next = level + LEVEL_ONE;
        end else if (!wr_ok && pop) begin
            level_next = level - LEVEL_ONE;
        end
    end

    assign drop_sum  = {1'b0, drop_count} + {{(DROP_W-1){1'b0}}, drop_inc};
    assign drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

    always_ff @(posedge sys_clk) begin
        if (wr_ok && !clear) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // clear outranks reads and writes in the same cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            seq        <= 6'd0;
            drop_count <= '0;
            rd_data    <= 32'h0000_0000;
            rd_valid   <= 1'b0;
            pend_v     <= 1'b0;
            pend_val   <= 8'h00;
            pend_ts    <= 16'h0000;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            seq        <= 6'd0;
            drop_count <= '0;
            rd_valid   <= 1'b0;
            pend_v     <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                seq    <= seq + 6'd1;
            end
            level      <= level_next;
            empty      <= (level_next == '0);
            full       <= (level_next == LEVEL_FULL);
            drop_count <= drop_next;
            pend_v     <= pend_v_next;
            pend_val   <= pend_val_next;
            pend_ts    <= pend_ts_next;
        end
    end

endmodule
